chip_discriminator: RTL and testbench
=====================================

# chip_discriminator

Downstream stage of the I and Q 20-tap channel filters in the iq_demod chain. It takes the filtered 5-bit I/Q sample pairs and computes a cross-product frequency discriminator. It then integrates and dumps over one chip period, with early/late timing correction, and emits one hard O-QPSK/MSK chip decision per chip. The chip stream feeds the despreader/correlator.

## Interface
- OSR, 4, samples per chip; legal values 2, 4, 8.

- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  one-cycle strobe; i_in/q_in hold a new filtered sample pair (both filters run in lockstep)
- i_in  in  5  signed filtered I sample
- q_in  in  5  signed filtered Q sample
- disc_out  out  11  signed discriminator value d
- disc_valid  out  1  one-cycle strobe qualifying disc_out
- chip_out  out  1  hard chip decision (1 = positive frequency)
- chip_valid  out  1  one-cycle strobe qualifying chip_out

## Operation
- Control FSM has two states, FILL and RUN.
  - Reset enters FILL.
  - In FILL, the first in_valid only loads Ip/Qp (previous sample). The FSM then moves to RUN and produces no output.
  - In RUN, every in_valid computes d = Q·Ip − I·Qp and then loads Ip/Qp with the current sample.
- Arithmetic:
  - Each product is 5×5 signed, giving 10-bit signed.
  - d is sign-extended to 11 bits and never wraps. Range is −496..496; the extreme is 256+240.
  - Counter-clockwise rotation gives d > 0.
- Pipeline:
  - P1 registers both products.
  - P2 registers d into disc_out and pulses disc_valid.
- Chip accumulator:
  - The accumulator is 14-bit signed.
  - The sample index counter cnt runs 0..OSR−1.
- Timing-error detection:
  - On each disc_valid, tr = sign(d) ≠ sign(d_last). Sign is bit 10, so 0 counts as positive.
  - d_last is invalid for the first d after reset, which forces tr=0.
  - d_last is then updated.
- Correction adjustment adj, applied at most once per chip via the corr flag:
  - adj = −1 (hold) if tr, !corr and 1 ≤ cnt ≤ OSR/2−1.
  - adj = +1 (advance) if tr, !corr and OSR/2 ≤ cnt ≤ OSR−2.
  - Otherwise adj = 0.
  - Whenever adj ≠ 0, set corr.
- Effective index e = cnt + adj.
  - Every disc_valid adds d into acc.
  - If e == OSR−1 (dump):
    - chip_out ← (acc+d ≥ 0).
    - chip_valid pulses.
    - acc ← 0, corr ← 0, cnt ← 0.
  - Else acc ← acc+d and cnt ← e+1.
- A hold lengthens the current chip by one sample; an advance shortens it by one.
- For OSR=2 both correction ranges are empty, so no correction occurs.
- No in_valid means no state change; samples may arrive with arbitrary gaps (min spacing 1 cycle).

## Timing
- Reset values:
  - disc_out=0, disc_valid=0, chip_out=0, chip_valid=0.
  - acc=0, cnt=0, corr=0, d_last invalid, Ip=Qp=0, state FILL.
- disc_valid is asserted 2 cycles after the in_valid cycle that produced it.
- chip_valid is asserted 3 cycles after the in_valid of the chip's last sample.
- chip_out holds its value until the next dump.
- Back-to-back in_valid gives fully pipelined throughput of one d per cycle.
- resetn asserted mid-chip clears all state immediately, including P1/P2 in flight. Pending disc_valid/chip_valid are dropped, and the next in_valid after release is a FILL sample.
- in_valid in the same cycle as reset release: the sample is ignored unless resetn is already high at the capturing edge.

## Test plan
- Reset: hold resetn low and drive in_valid → all outputs 0. First in_valid after release produces no disc_valid.
- CCW tone, OSR=4: I/Q sequence (7,0),(0,7),(−7,0),(0,−7), repeating, 1 fill sample + 4 samples →
  - four disc_out=+49;
  - chip_out=1 with chip_valid exactly 3 cycles after the 5th in_valid;
  - then one chip every 4 samples.
- CW tone, same amplitudes reversed → disc_out=−49, chip_out=0 every 4 samples.
- Extremes: prev (−16,15), cur (−16,−16) → disc_out=+496 (no wrap). Swapping prev and cur gives −496.
- Timing, OSR=4: direction flips every 4 d samples, but the first flip lands at cnt=1 → one hold. chip_valid spacing is 5 samples once, then 4. The flip then lands at cnt=0 with no further correction.
  - Flip at cnt=2 instead gives one advance, with spacing 3 then 4.
- Reset mid-chip: assert resetn after 2 of 4 samples → no chip_valid. After release, 1 fill + 4 samples yields a normal chip at the expected latency.

Source files
------------

// File: rtl/chip_discriminator.sv
// chip_discriminator: cross-product FM discriminator on filtered I/Q pairs,
// followed by an early/late corrected integrate-and-dump that emits one hard
// O-QPSK/MSK chip decision per chip period.
module chip_discriminator #(
   parameter int OSR = 4            // samples per chip: 2, 4 or 8
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        in_valid,
   input  logic [4:0]  i_in,
   input  logic [4:0]  q_in,
   output logic [10:0] disc_out,
   output logic        disc_valid,
   output logic        chip_out,
   output logic        chip_valid
);

   // cnt must hold 0..OSR (e+1 never exceeds OSR-1, but leave headroom)
   localparam int CW = $clog2(OSR) + 1;

   typedef enum logic {FILL, RUN} state_t;

   state_t             state;
   logic signed [4:0]  i_s, q_s;
   logic signed [4:0]  ip, qp;          // previous sample pair
   logic signed [9:0]  prod_a, prod_b;  // Q*Ip and I*Qp
   logic               p1_valid;
   logic signed [10:0] d_next;

   logic signed [13:0] acc;
   logic [CW-1:0]      cnt;
   logic               corr;            // a correction was already spent this chip
   logic               last_sign;
   logic               last_ok;         // d_last holds a real value

   logic               d_sign;
   logic               tr;
   logic               hold_win, adv_win;
   logic               hold, adv;
   logic [CW-1:0]      e;
   logic               dump;
   logic signed [13:0] d_ext;
   logic signed [13:0] acc_sum;

   assign i_s = i_in;
   assign q_s = q_in;

   // Control FSM and P1: first sample only primes Ip/Qp, then every sample
   // registers both cross products and becomes the new previous sample.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= FILL;
         ip       <= '0;
         qp       <= '0;
         prod_a   <= '0;
         prod_b   <= '0;
         p1_valid <= 1'b0;
      end else begin
         p1_valid <= 1'b0;
         if (in_valid) begin
            ip <= i_s;
            qp <= q_s;
            if (state == FILL) begin
               state <= RUN;
            end else begin
               prod_a   <= q_s * ip;
               prod_b   <= i_s * qp;
               p1_valid <= 1'b1;
            end
         end
      end
   end

   // 11 bits hold the full -496..496 range, so the difference never wraps
   assign d_next = {prod_a[9], prod_a} - {prod_b[9], prod_b};

   // P2: register the discriminator value; disc_out holds between strobes
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         disc_out   <= '0;
         disc_valid <= 1'b0;
      end else begin
         disc_valid <= p1_valid;
         if (p1_valid)
            disc_out <= d_next;
      end
   end

   // Timing-error detection and early/late window decode on the current d
   always_comb begin
      d_sign   = disc_out[10];
      tr       = last_ok && (d_sign != last_sign);
      hold_win = (cnt >= CW'(1)) && (cnt <= CW'(OSR/2 - 1));
      adv_win  = (cnt >= CW'(OSR/2)) && (cnt <= CW'(OSR - 2));
      hold     = tr && !corr && hold_win;
      adv      = tr && !corr && adv_win;
      e        = cnt;
      if (hold)
         e = cnt - CW'(1);
      else if (adv)
         e = cnt + CW'(1);
      dump     = (e == CW'(OSR - 1));
      d_ext    = {{3{disc_out[10]}}, disc_out};
      acc_sum  = acc + d_ext;
   end

   // Integrate-and-dump with at most one timing correction per chip
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc        <= '0;
         cnt        <= '0;
         corr       <= 1'b0;
         last_sign  <= 1'b0;
         last_ok    <= 1'b0;
         chip_out   <= 1'b0;
         chip_valid <= 1'b0;
      end else begin
         chip_valid <= 1'b0;
         if (disc_valid) begin
            last_sign <= d_sign;
            last_ok   <= 1'b1;
            if (hold || adv)
               corr <= 1'b1;
            if (dump) begin
               chip_out   <= ~acc_sum[13];
               chip_valid <= 1'b1;
               acc        <= '0;
               corr       <= 1'b0;
               cnt        <= '0;
            end else begin
               acc <= acc_sum;
               cnt <= e + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_chip_discriminator.sv
// Scoreboard bench for chip_discriminator: stimulus pushes expected d values
// and chip decisions (with their due cycle) into queues; a monitor pops them.
module tb_chip_discriminator;

   localparam int OSR = 4;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic [4:0]  i_in = '0;
   logic [4:0]  q_in = '0;
   logic [10:0] disc_out;
   logic        disc_valid;
   logic        chip_out;
   logic        chip_valid;

   chip_discriminator #(.OSR(OSR)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .in_valid  (in_valid),
      .i_in      (i_in),
      .q_in      (q_in),
      .disc_out  (disc_out),
      .disc_valid(disc_valid),
      .chip_out  (chip_out),
      .chip_valid(chip_valid)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   int exp_d_q[$];
   int exp_d_t[$];
   int exp_c_q[$];
   int exp_c_t[$];
   int hold_exp = 0;

   // behavioural reference state
   bit m_fill = 1'b1;
   int m_ip = 0, m_qp = 0;
   int m_cnt = 0, m_acc = 0;
   bit m_corr = 1'b0, m_have = 1'b0;
   int m_last = 0;

   int tab_i[4] = '{7, 0, -7, 0};
   int tab_q[4] = '{0, 7, 0, -7};

   function automatic void model_reset();
      m_fill = 1'b1; m_ip = 0; m_qp = 0; m_cnt = 0; m_acc = 0;
      m_corr = 1'b0; m_have = 1'b0; m_last = 0;
      exp_d_q.delete(); exp_d_t.delete(); exp_c_q.delete(); exp_c_t.delete();
      hold_exp = 0;
   endfunction

   // One sample as seen by the reference: frequency from the cross product,
   // then chip timing from integer counters.
   function automatic void model_sample(int i, int q);
      int d, adj, e;
      if (m_fill) begin
         m_ip = i; m_qp = q; m_fill = 1'b0;
         return;
      end
      d = q * m_ip - i * m_qp;
      m_ip = i; m_qp = q;
      exp_d_q.push_back(d);
      exp_d_t.push_back(cyc + 2);
      adj = 0;
      if (m_have && ((d < 0) != (m_last < 0)) && !m_corr) begin
         if (m_cnt >= 1 && m_cnt <= OSR/2 - 1) adj = -1;
         else if (m_cnt >= OSR/2 && m_cnt <= OSR - 2) adj = 1;
      end
      if (adj != 0) m_corr = 1'b1;
      m_last = d; m_have = 1'b1;
      e = m_cnt + adj;
      if (e == OSR - 1) begin
         exp_c_q.push_back((m_acc + d >= 0) ? 1 : 0);
         exp_c_t.push_back(cyc + 3);
         m_acc = 0; m_corr = 1'b0; m_cnt = 0;
      end else begin
         m_acc = m_acc + d;
         m_cnt = e + 1;
      end
   endfunction

   task automatic check(string name, int got, int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, got, exp);
      end
   endtask

   task automatic send(int i, int q);
      @(negedge clk);
      in_valid = 1'b1;
      i_in = i[4:0];
      q_in = q[4:0];
      if (resetn) model_sample(i, q);
   endtask

   task automatic idle(int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   // Reset just after an active edge so in-flight results are dropped
   task automatic do_reset(bit release_with_sample);
      int i, q;
      @(posedge clk);
      #2;
      resetn = 1'b0;
      in_valid = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      if (release_with_sample) begin
         i = $urandom_range(0, 31) - 16;
         q = $urandom_range(0, 31) - 16;
         in_valid = 1'b1;
         i_in = i[4:0];
         q_in = q[4:0];
         model_sample(i, q);
      end
   endtask

   // Rotating tone: fill sample, then n steps in direction dir
   task automatic rot(int dir, int n);
      int ph;
      ph = 0;
      send(tab_i[ph], tab_q[ph]);
      for (int k = 0; k < n; k++) begin
         ph = (ph + dir) & 3;
         send(tab_i[ph], tab_q[ph]);
      end
   endtask

   // Tone whose direction flips every 4 d, first flip after first_len d
   task automatic rot_flip(int first_len, int nblocks);
      int ph, dir;
      ph = 0; dir = 1;
      send(tab_i[ph], tab_q[ph]);
      for (int k = 0; k < first_len; k++) begin
         ph = (ph + dir) & 3;
         send(tab_i[ph], tab_q[ph]);
      end
      for (int b = 0; b < nblocks; b++) begin
         dir = -dir;
         for (int k = 0; k < 4; k++) begin
            ph = (ph + dir) & 3;
            send(tab_i[ph], tab_q[ph]);
         end
      end
   endtask

   // Monitor: pop and compare whenever the DUT presents an output
   always @(negedge clk) begin
      int got, ev, et;
      if (resetn) begin
         if (disc_valid) begin
            got = $signed(disc_out);
            if (exp_d_q.size() == 0) begin
               check("disc_unexpected", 1, 0);
            end else begin
               ev = exp_d_q.pop_front();
               et = exp_d_t.pop_front();
               check("disc_value", got, ev);
               check("disc_latency_cycle", cyc, et);
            end
         end else if (exp_d_t.size() > 0 && exp_d_t[0] <= cyc) begin
            check("disc_missing_at_cycle", cyc, -1);
            void'(exp_d_q.pop_front());
            void'(exp_d_t.pop_front());
         end
         if (chip_valid) begin
            if (exp_c_q.size() == 0) begin
               check("chip_unexpected", 1, 0);
            end else begin
               ev = exp_c_q.pop_front();
               et = exp_c_t.pop_front();
               check("chip_value", int'(chip_out), ev);
               check("chip_latency_cycle", cyc, et);
               hold_exp = ev;
            end
         end else begin
            check("chip_out_hold", int'(chip_out), hold_exp);
            if (exp_c_t.size() > 0 && exp_c_t[0] <= cyc) begin
               check("chip_missing_at_cycle", cyc, -1);
               void'(exp_c_q.pop_front());
               void'(exp_c_t.pop_front());
            end
         end
      end
   end

   initial begin
      int i, q, gap, waited;
      model_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      // reset held while samples are offered: outputs stay quiet
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         in_valid = 1'b1;
         i_in = 5'($urandom_range(0, 31));
         q_in = 5'($urandom_range(0, 31));
         check("reset_outputs", int'({disc_out, disc_valid, chip_out, chip_valid}), 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      resetn = 1'b1;
      model_reset();

      // CCW tone: +49 per sample, chip 1 every 4 samples
      rot(1, 12);
      idle(6);

      // CW tone: -49 per sample, chip 0
      do_reset(1'b0);
      rot(-1, 12);
      idle(6);

      // extremes: no wrap at +/-496
      do_reset(1'b0);
      send(-16, 15);
      send(-16, -16);
      idle(3);
      check("extreme_pos", int'($signed(disc_out)), 496);
      send(-16, 15);
      idle(3);
      check("extreme_neg", int'($signed(disc_out)), -496);

      // flip at cnt=1 -> hold; flip at cnt=2 -> advance
      do_reset(1'b0);
      rot_flip(1, 4);
      idle(6);
      do_reset(1'b0);
      rot_flip(2, 4);
      idle(6);

      // reset mid-chip, then a clean chip
      do_reset(1'b0);
      rot(1, 2);
      do_reset(1'b0);
      rot(1, 4);
      idle(6);

      // randomized samples, gaps and resets (some with a sample at release)
      do_reset(1'b1);
      for (int n = 0; n < 400; n++) begin
         i = $urandom_range(0, 31) - 16;
         q = $urandom_range(0, 31) - 16;
         send(i, q);
         gap = $urandom_range(0, 3);
         if (gap == 3) gap = 0;
         if (gap > 0) idle(gap);
         if ($urandom_range(0, 79) == 0) do_reset($urandom_range(0, 1) == 1);
      end
      idle(1);

      waited = 0;
      while ((exp_d_q.size() > 0 || exp_c_q.size() > 0) && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("drain_disc_pending", exp_d_q.size(), 0);
      check("drain_chip_pending", exp_c_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
